// File: rtl/branch_redirect_ctrl_if.sv
// Pipeline-side bundle for branch_redirect_ctrl.
// The pipeline uses the master modport. The controller uses the slave modport.
interface branch_redirect_ctrl_if;
    logic        ExValid;
    logic        ExBranchTaken;
    logic [31:0] ExTargetPc;
    logic [31:0] ExPc;
    logic        ExPredTaken;
    logic        FetchStall;
    logic [31:0] FetchPc;
    logic        PredTaken;
    logic        RedirectValid;
    logic [31:0] RedirectPc;
    logic        FlushIF;
    logic        FlushID;
    logic        HoldPipe;
    logic [15:0] MispredictCount;

    modport master (
        output ExValid, ExBranchTaken, ExTargetPc, ExPc, ExPredTaken, FetchStall, FetchPc,
        input  PredTaken, RedirectValid, RedirectPc, FlushIF, FlushID, HoldPipe, MispredictCount
    );

    modport slave (
        input  ExValid, ExBranchTaken, ExTargetPc, ExPc, ExPredTaken, FetchStall, FetchPc,
        output PredTaken, RedirectValid, RedirectPc, FlushIF, FlushID, HoldPipe, MispredictCount
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch mispredict redirect FSM with a saturating mispredict counter.
// Define BRANCH_PRED_EN to build in the 64-entry 2-bit predictor.
module branch_redirect_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    branch_redirect_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t      state;
    logic [31:0] redirect_pc;
    logic [15:0] mispredict_count;
    logic        redirect_valid;
    logic        flush_if;
    logic        flush_id;
    logic        hold_pipe;
    logic        mispredict;
    logic        ex_update;

    // While in REDIRECT, the EX stage holds a wrong-path instruction. It is ignored.
    assign ex_update  = (state == IDLE) && bus.ExValid;
    assign mispredict = ex_update && (bus.ExBranchTaken != bus.ExPredTaken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            redirect_pc      <= '0;
            mispredict_count <= '0;
            redirect_valid   <= 1'b0;
            flush_if         <= 1'b0;
            flush_id         <= 1'b0;
            hold_pipe        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mispredict) begin
                        state          <= REDIRECT;
                        redirect_pc    <= bus.ExTargetPc;
                        redirect_valid <= 1'b1;
                        flush_if       <= 1'b1;
                        flush_id       <= 1'b1;
                        hold_pipe      <= 1'b1;
                        if (mispredict_count != '1)
                            mispredict_count <= mispredict_count + 16'd1;
                    end
                end
                REDIRECT: begin
                    if (!bus.FetchStall) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                        flush_if       <= 1'b0;
                        flush_id       <= 1'b0;
                        hold_pipe      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.RedirectValid   = redirect_valid;
    assign bus.RedirectPc      = redirect_pc;
    assign bus.FlushIF         = flush_if;
    assign bus.FlushID         = flush_id;
    assign bus.HoldPipe        = hold_pipe;
    assign bus.MispredictCount = mispredict_count;

`ifdef BRANCH_PRED_EN
    logic [1:0] pred_table [0:63];
    logic [5:0] ex_idx;
    logic       unused_pc_bits;

    assign ex_idx         = bus.ExPc[7:2];
    assign unused_pc_bits = ^{bus.FetchPc[31:8], bus.FetchPc[1:0], bus.ExPc[31:8], bus.ExPc[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 64; i++)
                pred_table[i] <= 2'b01;
        end else if (ex_update) begin
            if (bus.ExBranchTaken) begin
                if (pred_table[ex_idx] != 2'b11)
                    pred_table[ex_idx] <= pred_table[ex_idx] + 2'b01;
            end else begin
                if (pred_table[ex_idx] != 2'b00)
                    pred_table[ex_idx] <= pred_table[ex_idx] - 2'b01;
            end
        end
    end

    // The read is taken from the registered table. A same-cycle update is therefore visible only after the edge.
    assign bus.PredTaken = pred_table[bus.FetchPc[7:2]][1];
`else
    logic unused_pc_bits;

    assign unused_pc_bits = ^{bus.FetchPc, bus.ExPc};
    assign bus.PredTaken  = 1'b0;
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl. Expected redirects are queued at issue and checked on RedirectValid.
module tb_branch_redirect_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_redirect_ctrl_if bus ();

    branch_redirect_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef BRANCH_PRED_EN
    localparam logic PRED_EN = 1'b1;
`else
    localparam logic PRED_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_count;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.ExValid       = 1'b0;
        bus.ExBranchTaken = 1'b0;
        bus.ExPredTaken   = 1'b0;
        bus.ExTargetPc    = 32'h0;
        bus.ExPc          = 32'h1000;
        bus.FetchStall    = 1'b0;
        bus.FetchPc       = 32'h0;
    endtask

    task automatic issue_mispredict(input logic [31:0] target, input logic taken, input logic stall);
        bus.ExValid       = 1'b1;
        bus.ExBranchTaken = taken;
        bus.ExPredTaken   = ~taken;
        bus.ExTargetPc    = target;
        bus.FetchStall    = stall;
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        sb.push_back('{pc: target, cnt: exp_count});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        exp_count = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.RedirectValid, bus.FlushIF, bus.FlushID, bus.HoldPipe} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=0000", {bus.RedirectValid, bus.FlushIF, bus.FlushID, bus.HoldPipe});
        end
        total++;
        if (bus.RedirectPc !== 32'h0) begin
            bad++;
            $display("FAIL reset_pc got=%h want=00000000", bus.RedirectPc);
        end
        total++;
        if (bus.MispredictCount !== 16'h0) begin
            bad++;
            $display("FAIL reset_cnt got=%h want=0000", bus.MispredictCount);
        end
        rst = 1'b0;
        step();
        total++;
        if ({bus.RedirectValid, bus.FlushIF, bus.FlushID, bus.HoldPipe} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_after_ctl got=%b want=0000", {bus.RedirectValid, bus.FlushIF, bus.FlushID, bus.HoldPipe});
        end
    endtask

    task automatic test_predictor();
        // Only correct predictions are used here, so the redirect FSM stays in IDLE.
        bus.FetchPc = 32'h40;
        bus.ExPc = 32'h40;
        bus.ExValid = 1'b1;
        bus.ExBranchTaken = 1'b1;
        bus.ExPredTaken = 1'b1;
        #1;
        total++;
        if (bus.PredTaken !== 1'b0) begin
            bad++;
            $display("FAIL pred_pre_update got=%b want=0", bus.PredTaken);
        end
        step();
        total++;
        if (bus.PredTaken !== PRED_EN) begin
            bad++;
            $display("FAIL pred_one_taken got=%b want=%b", bus.PredTaken, PRED_EN);
        end
        step();
        bus.ExValid = 1'b0;
        #1;
        total++;
        if (bus.PredTaken !== PRED_EN) begin
            bad++;
            $display("FAIL pred_two_taken got=%b want=%b", bus.PredTaken, PRED_EN);
        end
        bus.FetchPc = 32'h44;
        #1;
        total++;
        if (bus.PredTaken !== 1'b0) begin
            bad++;
            $display("FAIL pred_other_index got=%b want=0", bus.PredTaken);
        end
        // Decrement twice from the saturated-taken state: 11 -> 10 -> 01.
        bus.FetchPc = 32'h40;
        bus.ExValid = 1'b1;
        bus.ExBranchTaken = 1'b0;
        bus.ExPredTaken = 1'b0;
        step();
        total++;
        if (bus.PredTaken !== PRED_EN) begin
            bad++;
            $display("FAIL pred_dec_once got=%b want=%b", bus.PredTaken, PRED_EN);
        end
        step();
        drive_idle();
        bus.FetchPc = 32'h40;
        #1;
        total++;
        if (bus.PredTaken !== 1'b0) begin
            bad++;
            $display("FAIL pred_dec_twice got=%b want=0", bus.PredTaken);
        end
        total++;
        if ({bus.RedirectValid, bus.MispredictCount} !== {1'b0, exp_count}) begin
            bad++;
            $display("FAIL pred_no_redirect got=%b/%h want=0/%h", bus.RedirectValid, bus.MispredictCount, exp_count);
        end
    endtask

    task automatic test_basic_redirect();
        issue_mispredict(32'h120, 1'b1, 1'b0);
        #1;
        total++;
        if ({bus.RedirectValid, bus.FlushIF, bus.FlushID, bus.HoldPipe} !== 4'b0000) begin
            bad++;
            $display("FAIL basic_early got=%b want=0000", {bus.RedirectValid, bus.FlushIF, bus.FlushID, bus.HoldPipe});
        end
        step();
        drive_idle();
        total++;
        if ({bus.RedirectValid, bus.FlushIF, bus.FlushID, bus.HoldPipe} !== 4'b1111) begin
            bad++;
            $display("FAIL basic_ctl got=%b want=1111", {bus.RedirectValid, bus.FlushIF, bus.FlushID, bus.HoldPipe});
        end
        total++;
        if (bus.RedirectValid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            if ({bus.RedirectPc, bus.MispredictCount} !== {e.pc, e.cnt}) begin
                bad++;
                $display("FAIL basic_sb got=%h/%h want=%h/%h", bus.RedirectPc, bus.MispredictCount, e.pc, e.cnt);
            end
        end else begin
            bad++;
            $display("FAIL basic_sb got=no_redirect want=redirect");
        end
        step();
        total++;
        if ({bus.RedirectValid, bus.FlushIF, bus.FlushID, bus.HoldPipe} !== 4'b0000) begin
            bad++;
            $display("FAIL basic_idle got=%b want=0000", {bus.RedirectValid, bus.FlushIF, bus.FlushID, bus.HoldPipe});
        end
        total++;
        if ({bus.RedirectPc, bus.MispredictCount} !== {32'h120, 16'h1}) begin
            bad++;
            $display("FAIL basic_hold got=%h/%h want=00000120/0001", bus.RedirectPc, bus.MispredictCount);
        end
    endtask

    task automatic test_fetch_stall();
        // The mispredict is issued while FetchStall is high. FetchStall then drops after three REDIRECT cycles.
        issue_mispredict(32'h1004, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step();
            bus.ExValid = 1'b0;
            bus.FetchStall = (k < 4);
            total++;
            if ({bus.RedirectValid, bus.FlushIF, bus.FlushID, bus.HoldPipe, bus.RedirectPc} !== {4'b1111, 32'h1004}) begin
                bad++;
                $display("FAIL stall_hold_%0d got=%b/%h want=1111/00001004", k,
                         {bus.RedirectValid, bus.FlushIF, bus.FlushID, bus.HoldPipe}, bus.RedirectPc);
            end
            if (k == 1) begin
                total++;
                if (bus.RedirectValid === 1'b1 && sb.size() > 0) begin
                    e = sb.pop_front();
                    if ({bus.RedirectPc, bus.MispredictCount} !== {e.pc, e.cnt}) begin
                        bad++;
                        $display("FAIL stall_sb got=%h/%h want=%h/%h", bus.RedirectPc, bus.MispredictCount, e.pc, e.cnt);
                    end
                end else begin
                    bad++;
                    $display("FAIL stall_sb got=no_redirect want=redirect");
                end
            end
        end
        step();
        total++;
        if ({bus.RedirectValid, bus.FlushIF, bus.FlushID, bus.HoldPipe} !== 4'b0000) begin
            bad++;
            $display("FAIL stall_release got=%b want=0000", {bus.RedirectValid, bus.FlushIF, bus.FlushID, bus.HoldPipe});
        end
    endtask

    task automatic test_wrong_path();
        issue_mispredict(32'h120, 1'b1, 1'b1);
        step();
        total++;
        if (bus.RedirectValid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            if ({bus.RedirectPc, bus.MispredictCount} !== {e.pc, e.cnt}) begin
                bad++;
                $display("FAIL wrong_sb got=%h/%h want=%h/%h", bus.RedirectPc, bus.MispredictCount, e.pc, e.cnt);
            end
        end else begin
            bad++;
            $display("FAIL wrong_sb got=no_redirect want=redirect");
        end
        // A conflicting EX outcome arrives while the redirect is still pending.
        bus.ExValid = 1'b1;
        bus.ExBranchTaken = 1'b0;
        bus.ExPredTaken = 1'b1;
        bus.ExTargetPc = 32'h200;
        step();
        total++;
        if ({bus.RedirectValid, bus.RedirectPc, bus.MispredictCount} !== {1'b1, 32'h120, exp_count}) begin
            bad++;
            $display("FAIL wrong_ignored got=%b/%h/%h want=1/00000120/%h", bus.RedirectValid, bus.RedirectPc,
                     bus.MispredictCount, exp_count);
        end
        drive_idle();
        step();
        total++;
        if ({bus.RedirectValid, bus.RedirectPc, bus.MispredictCount} !== {1'b0, 32'h120, exp_count}) begin
            bad++;
            $display("FAIL wrong_idle got=%b/%h/%h want=0/00000120/%h", bus.RedirectValid, bus.RedirectPc,
                     bus.MispredictCount, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        issue_mispredict(32'h500, 1'b1, 1'b0);
        step();
        drive_idle();
        total++;
        if (bus.RedirectValid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            if ({bus.RedirectPc, bus.MispredictCount} !== {e.pc, e.cnt}) begin
                bad++;
                $display("FAIL b2b_first got=%h/%h want=%h/%h", bus.RedirectPc, bus.MispredictCount, e.pc, e.cnt);
            end
        end else begin
            bad++;
            $display("FAIL b2b_first got=no_redirect want=redirect");
        end
        step();
        issue_mispredict(32'h704, 1'b0, 1'b0);
        total++;
        if (bus.RedirectValid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap got=%b want=0", bus.RedirectValid);
        end
        step();
        // A correct prediction arrives during REDIRECT. It must be ignored.
        bus.ExValid = 1'b1;
        bus.ExBranchTaken = 1'b1;
        bus.ExPredTaken = 1'b1;
        bus.ExTargetPc = 32'h800;
        total++;
        if (bus.RedirectValid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            if ({bus.RedirectPc, bus.MispredictCount} !== {e.pc, e.cnt}) begin
                bad++;
                $display("FAIL b2b_second got=%h/%h want=%h/%h", bus.RedirectPc, bus.MispredictCount, e.pc, e.cnt);
            end
        end else begin
            bad++;
            $display("FAIL b2b_second got=no_redirect want=redirect");
        end
        step();
        bus.ExBranchTaken = 1'b0;
        bus.ExPredTaken = 1'b0;
        step();
        drive_idle();
        total++;
        if ({bus.RedirectValid, bus.RedirectPc, bus.MispredictCount} !== {1'b0, 32'h704, exp_count}) begin
            bad++;
            $display("FAIL b2b_correct_pred got=%b/%h/%h want=0/00000704/%h", bus.RedirectValid, bus.RedirectPc,
                     bus.MispredictCount, exp_count);
        end
    endtask

    task automatic test_saturation();
        force dut.mispredict_count = 16'hFFFF;
        #1;
        release dut.mispredict_count;
        exp_count = 16'hFFFF;
        for (int n = 0; n < 2; n++) begin
            issue_mispredict(32'h900 + 32'(n * 16), 1'b1, 1'b0);
            step();
            drive_idle();
            total++;
            if (bus.RedirectValid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                if ({bus.RedirectPc, bus.MispredictCount} !== {e.pc, e.cnt}) begin
                    bad++;
                    $display("FAIL sat_%0d got=%h/%h want=%h/%h", n, bus.RedirectPc, bus.MispredictCount, e.pc, e.cnt);
                end
            end else begin
                bad++;
                $display("FAIL sat_%0d got=no_redirect want=redirect", n);
            end
            step();
        end
        total++;
        if (bus.MispredictCount !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_final got=%h want=ffff", bus.MispredictCount);
        end
    endtask

    task automatic test_reset_mid_redirect();
        issue_mispredict(32'hA00, 1'b1, 1'b1);
        step();
        bus.ExValid = 1'b0;
        total++;
        if ({bus.RedirectValid, bus.RedirectPc} !== {1'b1, 32'hA00}) begin
            bad++;
            $display("FAIL rstmid_pre got=%b/%h want=1/00000a00", bus.RedirectValid, bus.RedirectPc);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.RedirectValid, bus.FlushIF, bus.FlushID, bus.HoldPipe, bus.RedirectPc, bus.MispredictCount}
            !== {4'b0000, 32'h0, 16'h0}) begin
            bad++;
            $display("FAIL rstmid_async got=%b/%h/%h want=0000/00000000/0000",
                     {bus.RedirectValid, bus.FlushIF, bus.FlushID, bus.HoldPipe}, bus.RedirectPc, bus.MispredictCount);
        end
        sb.delete();
        exp_count = '0;
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        step();
        total++;
        if ({bus.RedirectValid, bus.MispredictCount} !== {1'b0, 16'h0}) begin
            bad++;
            $display("FAIL rstmid_after got=%b/%h want=0/0000", bus.RedirectValid, bus.MispredictCount);
        end
    endtask

    initial begin
        test_reset();
        test_predictor();
        test_basic_redirect();
        test_fetch_stall();
        test_wrong_path();
        test_back_to_back();
        test_saturation();
        test_reset_mid_redirect();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ExValid  input  1  EX stage holds a resolved branch/jump this cycle.
REQ-005 ExBranchTaken  input  1  BRU taken decision.
REQ-006 ExTargetPc  input  32  BRU next-PC: target if taken, Pc+4 if not.
REQ-007 ExPc  input  32  PC of the EX-stage instruction.
REQ-008 ExPredTaken  input  1  prediction made at fetch for that instruction.
REQ-009 FetchStall  input  1  IF cannot accept a redirect this cycle.
REQ-010 FetchPc  input  32  PC being fetched (predictor lookup).
REQ-011 PredTaken  output  1  prediction for FetchPc.
REQ-012 RedirectValid  output  1  redirect request to IF.
REQ-013 RedirectPc  output  32  PC IF must load.
REQ-014 FlushIF  output  1  kill the IF/ID register.
REQ-015 FlushID  output  1  kill the ID/EX register.
REQ-016 HoldPipe  output  1  stall ID/EX advance.
REQ-017 MispredictCount  output  16  mispredict counter.

Function
REQ-018 Mispredict SHALL be defined as ExValid AND (ExBranchTaken != ExPredTaken), evaluated only in state IDLE.
REQ-019 The FSM SHALL have two states: IDLE and REDIRECT.
REQ-020 In IDLE on mispredict, the block SHALL capture ExTargetPc into RedirectPc and enter REDIRECT at the next edge; the latency is 1 cycle.
REQ-021 In REDIRECT, RedirectValid, FlushIF, FlushID and HoldPipe SHALL all be 1; in IDLE, all four SHALL be 0.
REQ-022 The handshake SHALL complete on a cycle in REDIRECT with FetchStall=0; the next state is IDLE.
REQ-023 While FetchStall=1, the block SHALL remain in REDIRECT with RedirectPc held stable.
REQ-024 ExValid in REDIRECT SHALL be ignored as wrong-path: no capture, no count, no predictor update.
REQ-025 Each detected mispredict SHALL increment MispredictCount by 1, saturating at 0xFFFF with no wrap.
REQ-026 A mispredict in IDLE with FetchStall=1 SHALL still enter REDIRECT, since FetchStall only gates completion.
REQ-027 RedirectPc SHALL remain unchanged in IDLE and hold the last redirect target.

Reset
REQ-028 Reset SHALL force: state IDLE, RedirectValid 0, FlushIF 0, FlushID 0, HoldPipe 0, RedirectPc 0x00000000, MispredictCount 0.
REQ-029 Reset asserted mid-REDIRECT SHALL abandon the redirect immediately, without waiting for a clock edge.
REQ-030 With BRANCH_PRED_EN defined, every predictor entry SHALL reset to 2'b01 (weakly not-taken).

Configuration
REQ-031 The macro BRANCH_PRED_EN SHALL select whether the branch predictor is compiled in.
REQ-032 With BRANCH_PRED_EN defined, the block SHALL hold a 64-entry table of 2-bit saturating counters.
REQ-033 Predictor read: PredTaken SHALL be counter[FetchPc[7:2]][1], combinational.
REQ-034 Predictor update: ExValid in IDLE SHALL update counter[ExPc[7:2]], incrementing if ExBranchTaken else decrementing, saturating at 2'b11 and 2'b00.
REQ-035 On a same-cycle read and write of one index, PredTaken SHALL return the pre-update value.
REQ-036 Without BRANCH_PRED_EN, there SHALL be no table and PredTaken SHALL be constant 0; all other behaviour is unchanged.

Verification
REQ-037 Scenario: ExValid=1, ExPredTaken=0, ExBranchTaken=1, ExTargetPc=0x00000120, FetchStall=0 -> next cycle RedirectValid=1, RedirectPc=0x120, FlushIF=FlushID=HoldPipe=1; the following cycle IDLE with all four at 0; MispredictCount=1.
REQ-038 Scenario: mispredict as above with FetchStall=1 for 3 cycles -> REDIRECT held 4 cycles with RedirectPc stable; returns to IDLE one cycle after FetchStall falls.
REQ-039 Scenario: ExValid=1 in REDIRECT with a conflicting outcome, ExTargetPc=0x200 -> RedirectPc stays 0x120 and the count is unchanged.
REQ-040 Scenario: rst pulsed mid-REDIRECT -> outputs 0 at once and MispredictCount=0.
REQ-041 Scenario: preload MispredictCount to 0xFFFF, then one mispredict -> count remains 0xFFFF.
REQ-042 Scenario (BRANCH_PRED_EN): two taken updates at ExPc=0x40 -> PredTaken=1 for FetchPc=0x40 and PredTaken=0 for FetchPc=0x44.
